// File: rtl/input_buffer_ctrl_if.sv
// input_buffer_ctrl_if: sequencer handshake plus 74HC595 chain pins of the write-data buffer controller.
interface input_buffer_ctrl_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  clear_buffer;
  logic                  load_data;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic                  done;
  logic                  ds;
  logic                  shcp;
  logic                  stcp;
  logic                  mr_bar;
  logic                  oe_bar;
  modport master (
    output clear_buffer, load_data, data_in,
    input  ready, done, ds, shcp, stcp, mr_bar, oe_bar
  );
  modport slave (
    input  clear_buffer, load_data, data_in,
    output ready, done, ds, shcp, stcp, mr_bar, oe_bar
  );
endinterface

// File: rtl/input_buffer_ctrl.sv
// input_buffer_ctrl: shifts a captured word MSB-first into a 74HC595 chain at a slow phase rate, then latches it.
module input_buffer_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int MAX_DELAY  = 100
) (
  input  logic                    clk_i,
  input  logic                    rst_bar_i,
  input_buffer_ctrl_if.slave      bus
);
  localparam int PW = $clog2(MAX_DELAY + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [PW-1:0] PC_MAX  = PW'(MAX_DELAY);
  localparam logic [PW-1:0] PC_HALF = PW'(MAX_DELAY >> 1);
  localparam logic [BW-1:0] BC_MAX  = BW'(DATA_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, LATCH} state_e;
  state_e                state_q, state_d;
  logic [PW-1:0]         pc_q, pc_d;
  logic [BW-1:0]         bc_q, bc_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                  ds_q, ds_d, shcp_q, shcp_d, stcp_q, stcp_d;
  logic                  mr_bar_q, mr_bar_d, oe_bar_q, oe_bar_d, done_q, done_d;
  logic                  wrap, late;
  always_comb begin
    wrap     = pc_q == PC_MAX;
    late     = pc_q >= PC_HALF;
    state_d  = state_q;
    pc_d     = (state_q == IDLE || wrap) ? '0 : pc_q + 1'b1;
    bc_d     = bc_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        state_d  = bus.clear_buffer ? CLEAR : bus.load_data ? SHIFT : IDLE;
        bc_d     = '0;
        shadow_d = (!bus.clear_buffer && bus.load_data) ? bus.data_in : shadow_q;
      end
      SHIFT: begin
        state_d = (wrap && bc_q == BC_MAX) ? LATCH : SHIFT;
        bc_d    = !wrap ? bc_q : (bc_q == BC_MAX) ? '0 : bc_q + 1'b1;
      end
      default: state_d = wrap ? IDLE : state_q;
    endcase
    // pin values are decoded from the current state and registered, so every pin lags by one cycle
    ds_d     = state_q == SHIFT && shadow_q[BC_MAX - bc_q];
    shcp_d   = state_q == SHIFT && late;
    stcp_d   = (state_q == CLEAR || state_q == LATCH) && late;
    mr_bar_d = !(state_q == CLEAR && !late);
    done_d   = (state_q == CLEAR || state_q == LATCH) && wrap;
    oe_bar_d = oe_bar_q && !(state_q == LATCH && wrap);
  end
  always_ff @(posedge clk_i or negedge rst_bar_i) begin
    if (!rst_bar_i) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      bc_q     <= '0;
      shadow_q <= '0;
      ds_q     <= 1'b0;
      shcp_q   <= 1'b0;
      stcp_q   <= 1'b0;
      mr_bar_q <= 1'b1;
      oe_bar_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bc_q     <= bc_d;
      shadow_q <= shadow_d;
      ds_q     <= ds_d;
      shcp_q   <= shcp_d;
      stcp_q   <= stcp_d;
      mr_bar_q <= mr_bar_d;
      oe_bar_q <= oe_bar_d;
      done_q   <= done_d;
    end
  end
  assign bus.ready  = state_q == IDLE;
  assign bus.done   = done_q;
  assign bus.ds     = ds_q;
  assign bus.shcp   = shcp_q;
  assign bus.stcp   = stcp_q;
  assign bus.mr_bar = mr_bar_q;
  assign bus.oe_bar = oe_bar_q;
endmodule

// File: tb/tb_input_buffer_ctrl.sv
// tb_input_buffer_ctrl: random load/clear traffic against a pin-level 595 chain model and an operation scoreboard.
module tb_input_buffer_ctrl;
  localparam int DW       = 128;
  localparam int MD       = 10;
  localparam int HALF     = MD / 2;
  localparam int LOAD_CYC = (DW + 1) * (MD + 1);
  localparam int CLR_CYC  = MD + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  input_buffer_ctrl_if #(.DATA_WIDTH(DW)) bus();
  input_buffer_ctrl #(.DATA_WIDTH(DW), .MAX_DELAY(MD)) dut (
    .clk_i(clk),
    .rst_bar_i(rst_n),
    .bus(bus)
  );
  typedef struct {
    bit          is_load;
    logic [DW-1:0] word;
    int          due;
    bit          oe_bar;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0;
  bit oe_exp = 1'b1;
  logic [DW-1:0] chain = '0, store = '0;
  int n_shcp = 0, n_stcp = 0, n_mr = 0, mr_low = 0;
  logic shcp_p = 1'b0, stcp_p = 1'b0, mr_p = 1'b1;
  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // board model: 595 chain plus per-operation edge statistics, checked whenever DONE pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      shcp_p = 1'b0; stcp_p = 1'b0; mr_p = 1'b1;
      n_shcp = 0; n_stcp = 0; n_mr = 0; mr_low = 0;
    end else begin
      if (!bus.mr_bar) chain = '0;
      else if (bus.shcp && !shcp_p) chain = {chain[DW-2:0], bus.ds};
      if (bus.stcp && !stcp_p) store = chain;
      if (bus.shcp && !shcp_p) n_shcp++;
      if (bus.stcp && !stcp_p) n_stcp++;
      if (!bus.mr_bar && mr_p) n_mr++;
      if (!bus.mr_bar) mr_low++;
      if (bus.done) begin
        if (sbq.size() == 0) chki("spurious_done", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("stored_word", store, e.is_load ? e.word : '0);
          chki("shcp_rises", n_shcp, e.is_load ? DW : 0);
          chki("stcp_rises", n_stcp, 1);
          chki("mr_pulses", n_mr, e.is_load ? 0 : 1);
          chki("mr_low_cycles", mr_low, e.is_load ? 0 : HALF);
          chki("done_cycle", cyc, e.due);
          chki("ready_at_done", int'(bus.ready), 1);
          chki("oe_bar_at_done", int'(bus.oe_bar), int'(e.oe_bar));
        end
        n_shcp = 0; n_stcp = 0; n_mr = 0; mr_low = 0;
      end
      shcp_p = bus.shcp; stcp_p = bus.stcp; mr_p = bus.mr_bar;
    end
  end
  task automatic issue(bit clr, bit ld, logic [DW-1:0] word);
    int t = 0;
    while (!bus.ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chki("ready_before_issue", int'(bus.ready), 1);
    bus.clear_buffer = clr;
    bus.load_data    = ld;
    bus.data_in      = word;
    if (clr || ld) begin
      if (!clr) oe_exp = 1'b0;
      sbq.push_back('{is_load: !clr, word: word, due: cyc + 1 + (clr ? CLR_CYC : LOAD_CYC), oe_bar: oe_exp});
    end
    @(negedge clk);
    bus.clear_buffer = 1'b0;
    bus.load_data    = 1'b0;
    bus.data_in      = rnd_word();
  endtask
  task automatic busy_pulse(bit clr, bit ld, int after);
    repeat (after) @(negedge clk);
    bus.clear_buffer = clr;
    bus.load_data    = ld;
    bus.data_in      = rnd_word();
    @(negedge clk);
    bus.clear_buffer = 1'b0;
    bus.load_data    = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    while (sbq.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chki("op_timeout_pending", sbq.size(), 0);
    sbq.delete();
    repeat (3) @(negedge clk);
  endtask
  initial begin
    logic [DW-1:0] w;
    bus.clear_buffer = 1'b0;
    bus.load_data    = 1'b0;
    bus.data_in      = '0;
    #12;
    chki("reset_pins", int'({bus.ready, bus.mr_bar, bus.oe_bar, bus.shcp, bus.stcp, bus.ds, bus.done}), 7'b1110000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chki("idle_pins", int'({bus.ready, bus.mr_bar, bus.oe_bar, bus.shcp, bus.stcp, bus.ds, bus.done}), 7'b1110000);
    end
    w = {64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF};
    issue(1'b0, 1'b1, w);
    wait_done();
    chki("oe_after_load", int'(bus.oe_bar), 0);
    issue(1'b1, 1'b0, rnd_word());
    wait_done();
    chki("oe_after_clear", int'(bus.oe_bar), 0);
    issue(1'b1, 1'b1, rnd_word());
    wait_done();
    issue(1'b0, 1'b1, '1);
    wait_done();
    w = rnd_word();
    issue(1'b0, 1'b1, w);
    busy_pulse(1'b0, 1'b1, 200);
    busy_pulse(1'b1, 1'b0, 400);
    busy_pulse(1'b1, 1'b1, 300);
    wait_done();
    repeat (30) @(negedge clk);
    chk("ignored_requests_word", store, w);
    issue(1'b0, 1'b1, rnd_word());
    repeat (60 * (MD + 1) + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chki("async_reset_pins", int'({bus.ready, bus.mr_bar, bus.oe_bar, bus.shcp, bus.stcp, bus.ds, bus.done}), 7'b1110000);
    sbq.delete();
    oe_exp = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chki("ready_after_reset", int'(bus.ready), 1);
    issue(1'b0, 1'b1, rnd_word());
    wait_done();
    for (int i = 0; i < 6; i++) begin
      int k = $urandom_range(0, 2);
      issue(k != 1, k != 0, rnd_word());
      if ($urandom_range(0, 1) == 1) busy_pulse($urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 8));
      wait_done();
    end
    repeat (20) @(negedge clk);
    chki("queue_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
